// File: rtl/hazard_pkg.sv
// Shared constants for the hazard control unit: FSM encoding, the hard-wired
// zero register and a constant-friendly ceil(log2) helper.
package hazard_pkg;

   localparam logic [1:0] RUN = 2'd0;
   localparam logic [1:0] MDU = 2'd1;

   localparam logic [4:0] REG_ZERO = 5'd0;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side bundle for the hazard control unit. The slave modport is the
// hazard unit itself; the master modport is the pipeline that feeds it.
interface hazard_control_unit_if #(
   parameter int CNT_W = 16
);

   logic             MemRead_id_ex;
   logic             RegWrite_id_ex;
   logic [4:0]       Rd_id_ex;
   logic             MemRead_ex_mem;
   logic [4:0]       Rd_ex_mem;
   logic [4:0]       Rs_if_id;
   logic [4:0]       Rt_if_id;
   logic             uses_rt_if_id;
   logic             branch_id;
   logic             branch_taken_id;
   logic             mdu_start;

   logic             PCWrite;
   logic             IFIDWrite;
   logic             IDEXWrite;
   logic             bubble_id_ex;
   logic             bubble_ex_mem;
   logic             flush_if_id;
   logic             mdu_busy;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;
   logic [1:0]       dbg_state;

   modport master (
      output MemRead_id_ex, RegWrite_id_ex, Rd_id_ex, MemRead_ex_mem, Rd_ex_mem,
             Rs_if_id, Rt_if_id, uses_rt_if_id, branch_id, branch_taken_id,
             mdu_start,
      input  PCWrite, IFIDWrite, IDEXWrite, bubble_id_ex, bubble_ex_mem,
             flush_if_id, mdu_busy, stall_count, flush_count, dbg_state
   );

   modport slave (
      input  MemRead_id_ex, RegWrite_id_ex, Rd_id_ex, MemRead_ex_mem, Rd_ex_mem,
             Rs_if_id, Rt_if_id, uses_rt_if_id, branch_id, branch_taken_id,
             mdu_start,
      output PCWrite, IFIDWrite, IDEXWrite, bubble_id_ex, bubble_ex_mem,
             flush_if_id, mdu_busy, stall_count, flush_count, dbg_state
   );

endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller beside ID: load-use and branch-operand stalls,
// taken-branch IF/ID flush and a front-end freeze while mult/div owns EX.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int MDU_LATENCY = 4,
   parameter int CNT_W       = 16
) (
   input logic                  clk,
   input logic                  rst,
   hazard_control_unit_if.slave bus
);

   localparam int CW = (clog2(MDU_LATENCY) < 1) ? 1 : clog2(MDU_LATENCY);

   logic [1:0]    state;
   logic [1:0]    state_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;

   logic lu;
   logic br;
   logic rd_id_ex_hits;
   logic rd_ex_mem_hits;

   // A branch compares rs and rt in ID, so both are live regardless of uses_rt.
   assign rd_id_ex_hits  = (bus.Rd_id_ex != REG_ZERO) &&
                           ((bus.Rd_id_ex == bus.Rs_if_id) || (bus.Rd_id_ex == bus.Rt_if_id));
   assign rd_ex_mem_hits = (bus.Rd_ex_mem != REG_ZERO) &&
                           ((bus.Rd_ex_mem == bus.Rs_if_id) || (bus.Rd_ex_mem == bus.Rt_if_id));

   assign lu = bus.MemRead_id_ex && (bus.Rd_id_ex != REG_ZERO) &&
               ((bus.Rd_id_ex == bus.Rs_if_id) ||
                (bus.uses_rt_if_id && (bus.Rd_id_ex == bus.Rt_if_id)));

   assign br = bus.branch_id &&
               ((bus.RegWrite_id_ex && rd_id_ex_hits) ||
                (bus.MemRead_ex_mem && rd_ex_mem_hits));

   always_comb begin
      bus.PCWrite       = 1'b1;
      bus.IFIDWrite     = 1'b1;
      bus.IDEXWrite     = 1'b1;
      bus.bubble_id_ex  = 1'b0;
      bus.bubble_ex_mem = 1'b0;
      bus.flush_if_id   = 1'b0;
      bus.mdu_busy      = 1'b0;
      state_next        = state;
      cnt_next          = cnt;

      if (rst) begin
         state_next = RUN;
         cnt_next   = '0;
      end else begin
         case (state)
            RUN: begin
               if (bus.mdu_start) begin
                  // The start cycle is already the first EX cycle of the op.
                  bus.PCWrite   = 1'b0;
                  bus.IFIDWrite = 1'b0;
                  bus.IDEXWrite = 1'b0;
                  state_next    = MDU;
                  cnt_next      = CW'(MDU_LATENCY - 2);
               end else if (lu || br) begin
                  bus.PCWrite      = 1'b0;
                  bus.IFIDWrite    = 1'b0;
                  bus.bubble_id_ex = 1'b1;
               end else if (bus.branch_taken_id) begin
                  bus.flush_if_id = 1'b1;
               end
            end
            MDU: begin
               bus.PCWrite   = 1'b0;
               bus.IFIDWrite = 1'b0;
               bus.IDEXWrite = 1'b0;
               bus.mdu_busy  = 1'b1;
               // Last cycle lets the finished result move on into MEM.
               if (cnt == '0) begin
                  state_next = RUN;
               end else begin
                  bus.bubble_ex_mem = 1'b1;
                  cnt_next          = cnt - 1'b1;
               end
            end
            default: begin
               state_next = RUN;
               cnt_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   assign bus.dbg_state = state;

   sat_counter #(.CNT_W(CNT_W)) u_stall_count (
      .clk   (clk),
      .rst   (rst),
      .inc   (~bus.PCWrite),
      .count (bus.stall_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_count (
      .clk   (clk),
      .rst   (rst),
      .inc   (bus.flush_if_id),
      .count (bus.flush_count)
   );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized and directed bench for hazard_control_unit against a cycle-level
// behavioural model of stall, flush and mult/div freeze rules.
module tb_hazard_control_unit;

   localparam int LAT   = 4;
   localparam int CNT_W = 4;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic clk;
   logic rst;

   hazard_control_unit_if #(.CNT_W(CNT_W)) bus ();

   hazard_control_unit #(.MDU_LATENCY(LAT), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;
   logic [31:0] exp_q[$];

   // model state: remaining frozen MDU cycles after the start cycle, and event totals
   int m_rem;
   int m_stall;
   int m_flush;

   // last sampled DUT values, used by directed tallies
   logic [6:0] s_ctrl;
   logic [1:0] s_state;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // expected control vector {PCWrite,IFIDWrite,IDEXWrite,bubble_id_ex,bubble_ex_mem,flush_if_id,mdu_busy}
   function automatic logic [6:0] model_ctrl();
      bit lu;
      bit br;
      bit dep_id_ex;
      bit dep_ex_mem;
      if (rst) return 7'b1110000;
      if (m_rem > 0) return {4'b0000, (m_rem > 1) ? 1'b1 : 1'b0, 1'b0, 1'b1};
      if (bus.mdu_start) return 7'b0000000;
      lu = bus.MemRead_id_ex && bus.Rd_id_ex != 0 &&
           (bus.Rd_id_ex == bus.Rs_if_id || (bus.uses_rt_if_id && bus.Rd_id_ex == bus.Rt_if_id));
      dep_id_ex  = bus.Rd_id_ex  != 0 && (bus.Rd_id_ex  == bus.Rs_if_id || bus.Rd_id_ex  == bus.Rt_if_id);
      dep_ex_mem = bus.Rd_ex_mem != 0 && (bus.Rd_ex_mem == bus.Rs_if_id || bus.Rd_ex_mem == bus.Rt_if_id);
      br = bus.branch_id && ((bus.RegWrite_id_ex && dep_id_ex) || (bus.MemRead_ex_mem && dep_ex_mem));
      if (lu || br) return 7'b0011000;
      if (bus.branch_taken_id) return 7'b1110010;
      return 7'b1110000;
   endfunction

   // driver tasks
   task automatic drive_idle();
      bus.MemRead_id_ex   = 1'b0;
      bus.RegWrite_id_ex  = 1'b0;
      bus.Rd_id_ex        = 5'd0;
      bus.MemRead_ex_mem  = 1'b0;
      bus.Rd_ex_mem       = 5'd0;
      bus.Rs_if_id        = 5'd0;
      bus.Rt_if_id        = 5'd0;
      bus.uses_rt_if_id   = 1'b0;
      bus.branch_id       = 1'b0;
      bus.branch_taken_id = 1'b0;
      bus.mdu_start       = 1'b0;
   endtask

   task automatic drive_random();
      rst                 = ($urandom_range(0, 59) == 0);
      bus.MemRead_id_ex   = $urandom_range(0, 1);
      bus.RegWrite_id_ex  = $urandom_range(0, 1);
      bus.Rd_id_ex        = 5'($urandom_range(0, 3));
      bus.MemRead_ex_mem  = $urandom_range(0, 1);
      bus.Rd_ex_mem       = 5'($urandom_range(0, 3));
      bus.Rs_if_id        = 5'($urandom_range(0, 3));
      bus.Rt_if_id        = 5'($urandom_range(0, 3));
      bus.uses_rt_if_id   = $urandom_range(0, 1);
      bus.branch_id       = $urandom_range(0, 1);
      bus.branch_taken_id = $urandom_range(0, 1);
      bus.mdu_start       = ($urandom_range(0, 7) == 0);
   endtask

   // one clock cycle: sample and score outputs, then advance the model across the edge
   task automatic step();
      logic [6:0] e_ctrl;
      logic [1:0] e_state;
      #1;
      e_ctrl  = model_ctrl();
      e_state = (m_rem > 0) ? 2'd1 : 2'd0;
      exp_q.push_back(32'(e_ctrl));
      exp_q.push_back(32'(m_stall));
      exp_q.push_back(32'(m_flush));
      exp_q.push_back(32'(e_state));
      s_ctrl  = {bus.PCWrite, bus.IFIDWrite, bus.IDEXWrite, bus.bubble_id_ex,
                 bus.bubble_ex_mem, bus.flush_if_id, bus.mdu_busy};
      s_state = bus.dbg_state;
      check("ctrl",        32'(s_ctrl),          exp_q.pop_front());
      check("stall_count", 32'(bus.stall_count), exp_q.pop_front());
      check("flush_count", 32'(bus.flush_count), exp_q.pop_front());
      check("state",       32'(s_state),         exp_q.pop_front());
      @(posedge clk);
      if (rst) begin
         m_rem   = 0;
         m_stall = 0;
         m_flush = 0;
      end else begin
         if (!e_ctrl[6] && m_stall < SAT) m_stall++;
         if (e_ctrl[1] && m_flush < SAT) m_flush++;
         if (m_rem > 0) m_rem--;
         else if (bus.mdu_start) m_rem = LAT - 1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int pc0;
      int busy;
      int bex;
      int flush;
      n_vec   = 0;
      n_err   = 0;
      m_rem   = 0;
      m_stall = 0;
      m_flush = 0;
      drive_idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      step();
      rst = 1'b0;

      // load-use for one cycle
      bus.MemRead_id_ex = 1'b1; bus.Rd_id_ex = 5'd5; bus.Rs_if_id = 5'd5;
      step();
      check("lu_ctrl", 32'(s_ctrl), 32'(7'b0011000));
      bus.Rd_id_ex = 5'd0;
      step();
      check("lu_release", 32'(s_ctrl), 32'(7'b1110000));
      check("lu_stall_count", 32'(bus.stall_count), 32'd1);

      // register zero and unused rt never stall
      do_reset();
      bus.MemRead_id_ex = 1'b1; bus.Rd_id_ex = 5'd0; bus.Rs_if_id = 5'd0;
      step();
      check("zero_reg", 32'(s_ctrl[6]), 32'd1);
      bus.Rd_id_ex = 5'd7; bus.Rt_if_id = 5'd7; bus.uses_rt_if_id = 1'b0; bus.Rs_if_id = 5'd1;
      step();
      check("rt_unused", 32'(s_ctrl[6]), 32'd1);

      // load followed by beq: two stall cycles, then flush
      do_reset();
      bus.MemRead_id_ex = 1'b1; bus.Rd_id_ex = 5'd3; bus.branch_id = 1'b1; bus.Rs_if_id = 5'd3;
      step();
      bus.MemRead_id_ex = 1'b0; bus.Rd_id_ex = 5'd0;
      bus.MemRead_ex_mem = 1'b1; bus.Rd_ex_mem = 5'd3;
      step();
      check("ldbr_stall2", 32'(s_ctrl[6]), 32'd0);
      bus.MemRead_ex_mem = 1'b0; bus.Rd_ex_mem = 5'd0; bus.branch_taken_id = 1'b1;
      step();
      check("ldbr_stall_count", 32'(bus.stall_count), 32'd2);
      bus.branch_taken_id = 1'b0; bus.branch_id = 1'b0;
      step();
      check("ldbr_flush_count", 32'(bus.flush_count), 32'd1);

      // mult/div freeze with a taken branch pending in ID
      do_reset();
      pc0 = 0; busy = 0; bex = 0; flush = 0;
      bus.mdu_start = 1'b1;
      for (int i = 0; i < LAT; i++) begin
         step();
         bus.mdu_start = 1'b0;
         bus.branch_taken_id = 1'b1;
         pc0   += (s_ctrl[6] == 1'b0) ? 1 : 0;
         bex   += s_ctrl[2] ? 1 : 0;
         flush += s_ctrl[1] ? 1 : 0;
         busy  += s_ctrl[0] ? 1 : 0;
      end
      check("mdu_pc0_cycles",  32'(pc0),   32'd4);
      check("mdu_busy_cycles", 32'(busy),  32'd3);
      check("mdu_bex_cycles",  32'(bex),   32'd2);
      check("mdu_flush",       32'(flush), 32'd0);
      step();
      check("mdu_exit_flush", 32'(s_ctrl[1]), 32'd1);

      // reset in the second MDU cycle
      do_reset();
      bus.mdu_start = 1'b1;
      step();
      bus.mdu_start = 1'b0;
      step();
      rst = 1'b1;
      step();
      check("rst_mid_mdu_ctrl", 32'(s_ctrl), 32'(7'b1110000));
      rst = 1'b0;
      step();
      check("rst_mid_mdu_state", 32'(s_state), 32'd0);
      check("rst_mid_mdu_stall", 32'(bus.stall_count), 32'd0);

      // saturation of the stall counter
      do_reset();
      bus.MemRead_id_ex = 1'b1; bus.Rd_id_ex = 5'd5; bus.Rs_if_id = 5'd5;
      repeat (20) step();
      check("stall_saturate", 32'(bus.stall_count), 32'd15);

      // random traffic
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         drive_random();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline; it is the counterpart to forwarding_unit.
- Forwarding resolves hazards by bypassing data forward into EX. This block resolves the hazards that forwarding cannot cover:
  - load-use;
  - branch operands needed in ID;
  - multi-cycle multiply/divide.
- It does this by holding pipeline registers, inserting bubbles and flushing IF/ID.
- Sits beside the ID stage. Its outputs drive the PC, IF/ID, ID/EX and EX/MEM register enables.

Parameters:
- MDU_LATENCY, 4, total cycles a mult/div occupies EX (must be >= 2)
- CNT_W, 16, width of the performance counters

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- MemRead_id_ex  input  1  instruction in ID/EX is a load
- RegWrite_id_ex  input  1  instruction in ID/EX writes a register
- Rd_id_ex  input  5  destination of ID/EX (after RegDst mux)
- MemRead_ex_mem  input  1  instruction in EX/MEM is a load
- Rd_ex_mem  input  5  destination of EX/MEM
- Rs_if_id  input  5  rs field of the instruction in ID
- Rt_if_id  input  5  rt field of the instruction in ID
- uses_rt_if_id  input  1  ID instruction reads rt (R-type, beq, bne, sw)
- branch_id  input  1  ID instruction is beq/bne
- branch_taken_id  input  1  branch/jump in ID resolved taken
- mdu_start  input  1  ID/EX holds mult/div entering EX this cycle
- PCWrite  output  1  PC enable
- IFIDWrite  output  1  IF/ID enable
- IDEXWrite  output  1  ID/EX enable
- bubble_id_ex  output  1  zero control bits entering ID/EX
- bubble_ex_mem  output  1  zero control bits entering EX/MEM
- flush_if_id  output  1  replace IF/ID with nop
- mdu_busy  output  1  FSM in MDU state
- stall_count  output  CNT_W  cycles with PCWrite=0, saturating
- flush_count  output  CNT_W  cycles with flush_if_id=1, saturating

Behaviour:
- Hazard terms (combinational; register 0 never matches):
  - lu = MemRead_id_ex & Rd_id_ex!=0 & (Rd_id_ex==Rs_if_id | (uses_rt_if_id & Rd_id_ex==Rt_if_id)).
  - br = branch_id & [(RegWrite_id_ex & Rd_id_ex matches Rs_if_id/Rt_if_id) | (MemRead_ex_mem & Rd_ex_mem!=0 & Rd_ex_mem matches Rs_if_id/Rt_if_id)].
  - A load followed by a branch therefore stalls 2 cycles: br is re-evaluated each cycle.
- FSM states: RUN, MDU. 2-bit state plus a counter of width clog2(MDU_LATENCY).
- RUN output priority (first match wins):
  1. mdu_start: PCWrite=IFIDWrite=IDEXWrite=0, bubble_ex_mem=0, next MDU with cnt=MDU_LATENCY-2. The first EX cycle is the current one.
  2. lu|br: PCWrite=IFIDWrite=0, bubble_id_ex=1, stay RUN.
  3. branch_taken_id: flush_if_id=1, all enables 1.
  4. Otherwise all enables 1, bubbles/flush 0.
- MDU state:
  - PCWrite=IFIDWrite=IDEXWrite=0, bubble_ex_mem=1, mdu_busy=1.
  - All ID-side inputs are ignored: no flush, no lu/br.
  - cnt decrements each cycle. On cnt==0 next state is RUN, with bubble_ex_mem=0 in that final cycle so the result advances.
  - Total front-end freeze = MDU_LATENCY cycles including the mdu_start cycle.
- rst=1 (any state, including mid-MDU):
  - Outputs forced to RUN idle values: PCWrite=IFIDWrite=IDEXWrite=1, bubbles/flush/mdu_busy=0.
  - Next state RUN, cnt=0, both counters 0.
- Counters:
  - Increment on the clock edge when their condition is true and rst=0.
  - Hold at all-ones on overflow.
- All outputs except the counters are combinational from state and inputs. There is no added latency.

Decomposition:
- Package hazard_pkg holds:
  - state encoding: RUN=2'd0, MDU=2'd1;
  - REG_ZERO=5'd0;
  - function clog2.
- One sub-module: sat_counter (CNT_W, inc, rst), instantiated twice, for stall_count and flush_count.

Test Plan:
- Load-use: MemRead_id_ex=1, Rd_id_ex=5, Rs_if_id=5 for 1 cycle, then Rd_id_ex cleared -> exactly 1 cycle PCWrite=0, IFIDWrite=0, bubble_id_ex=1; stall_count=1.
- Register zero / rt unused: MemRead_id_ex=1, Rd_id_ex=0, Rs_if_id=0; then Rd_id_ex=7, Rt_if_id=7, uses_rt_if_id=0 -> no stall in either case.
- Load then beq: cycle0 MemRead_id_ex=1, Rd_id_ex=3, branch_id=1, Rs_if_id=3; cycle1 MemRead_ex_mem=1, Rd_ex_mem=3 -> stall in both cycles, stall_count=2. Cycle2 branch_taken_id=1 -> flush_if_id=1, flush_count=1.
- MDU: MDU_LATENCY=4, mdu_start=1 with branch_taken_id=1 during the MDU state -> PCWrite=0 for 4 cycles, mdu_busy=1 for 3, bubble_ex_mem=1 for 2, flush_if_id never 1.
- Reset mid-MDU: rst=1 in 2nd MDU cycle -> same-cycle outputs idle, next cycle RUN, counters 0.
- Saturation: CNT_W=4, hold a load-use hazard for 20 cycles -> stall_count stops at 15.
